// File: rtl/led_blinker_bank_if.sv
// ----------------------------------------------------------------------------
// led_blinker_bank_if
//   Configuration write port for led_blinker_bank. The controller drives it
//   through the master modport, and the blinker bank receives it through the
//   slave modport.
//
//   cfg_we     1      config write strobe, one cycle
//   cfg_ch     CHW    target channel; indices >= NCH are ignored by the bank
//   cfg_mode   2      0=OFF 1=ON 2=BLINK 3=BURST
//   cfg_half   HW     half-period in ticks (0 treated as 1)
//   cfg_burst  BW     number of high pulses in BURST mode
// ----------------------------------------------------------------------------
interface led_blinker_bank_if #(
    parameter int NCH = 8,
    parameter int HW  = 16,
    parameter int BW  = 4
);
    // The channel index has room for at least one out-of-range code, so a
    // bad index reaches the bank and is dropped there. It is not silently
    // truncated onto a real channel.
    localparam int CHW = $clog2(NCH + 1);

    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [1:0]     cfg_mode;
    logic [HW-1:0]  cfg_half;
    logic [BW-1:0]  cfg_burst;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_mode,
        output cfg_half,
        output cfg_burst
    );

    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_mode,
        input cfg_half,
        input cfg_burst
    );
endinterface

// File: rtl/led_blinker_bank.sv
// ----------------------------------------------------------------------------
// led_blinker_bank
//   Multi-channel LED blinker. A shared prescaler produces a slow tick. Each
//   channel runs independently in one of four modes: OFF, ON, BLINK
//   (free-running) or BURST (N high pulses, then OFF with a one-cycle done
//   pulse).
//
//   clk    in   1      system clock
//   rst    in   1      asynchronous, active-high reset
//   cfg    slave       configuration write port (led_blinker_bank_if)
//   led    out  NCH    LED drive, registered
//   busy   out  NCH    channel is in BLINK or BURST
//   done   out  NCH    one-cycle pulse when a BURST completes
// ----------------------------------------------------------------------------
module led_blinker_bank #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int NCH     = 8,
    parameter int HW      = 16,
    parameter int BW      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    led_blinker_bank_if.slave        cfg,
    output logic [NCH-1:0]           led,
    output logic [NCH-1:0]           busy,
    output logic [NCH-1:0]           done
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CHW      = $clog2(NCH + 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    // ------------------------------------------------------------------
    // Shared prescaler. It is free-running and is not restarted by config writes.
    // ------------------------------------------------------------------
    logic [PW-1:0] pre_q;
    logic          tick;

    assign tick = (pre_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    mode_t          mode_q  [NCH];
    mode_t          mode_d  [NCH];
    logic [HW-1:0]  half_q  [NCH];
    logic [HW-1:0]  half_d  [NCH];
    logic [HW-1:0]  cnt_q   [NCH];
    logic [HW-1:0]  cnt_d   [NCH];
    logic [BW-1:0]  burst_q [NCH];
    logic [BW-1:0]  burst_d [NCH];
    logic [NCH-1:0] led_q;
    logic [NCH-1:0] led_d;
    logic [NCH-1:0] done_q;
    logic [NCH-1:0] done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                mode_q[i]  <= MODE_OFF;
                half_q[i]  <= HW'(1);
                cnt_q[i]   <= '0;
                burst_q[i] <= '0;
            end
            led_q  <= '0;
            done_q <= '0;
        end else begin
            mode_q  <= mode_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. A write to a channel takes priority over that
    // channel's tick in the same cycle, so the tick is dropped and the
    // phase restarts from cnt=0. done defaults low, which makes it a
    // single-cycle pulse and also clears it on any write.
    always_comb begin
        mode_d  = mode_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        led_d   = led_q;
        done_d  = '0;

        for (int unsigned i = 0; i < NCH; i++) begin
            if (cfg.cfg_we && (cfg.cfg_ch == CHW'(i))) begin
                mode_d[i]  = mode_t'(cfg.cfg_mode);
                half_d[i]  = (cfg.cfg_half == '0) ? HW'(1) : cfg.cfg_half;
                cnt_d[i]   = '0;
                burst_d[i] = cfg.cfg_burst;
                unique case (mode_t'(cfg.cfg_mode))
                    MODE_OFF:   led_d[i] = 1'b0;
                    MODE_ON:    led_d[i] = 1'b1;
                    MODE_BLINK: led_d[i] = 1'b1;
                    MODE_BURST: begin
                        if (cfg.cfg_burst != '0) begin
                            led_d[i] = 1'b1;
                        end else begin
                            // An empty burst degenerates to OFF with no done pulse.
                            mode_d[i] = MODE_OFF;
                            led_d[i]  = 1'b0;
                        end
                    end
                endcase
            end else if (tick && (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_BURST)) begin
                if (cnt_q[i] == half_q[i] - HW'(1)) begin
                    cnt_d[i] = '0;
                    led_d[i] = ~led_q[i];
                    // Each pulse is counted on its falling edge. The last
                    // pulse leaves the LED low and sets the channel to OFF.
                    if (mode_q[i] == MODE_BURST && led_q[i]) begin
                        burst_d[i] = burst_q[i] - BW'(1);
                        if (burst_q[i] == BW'(1)) begin
                            mode_d[i] = MODE_OFF;
                            done_d[i] = 1'b1;
                        end
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + HW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            busy[i] = (mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_BURST);
        end
    end

    assign led  = led_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_blinker_bank.sv
// ----------------------------------------------------------------------------
// tb_led_blinker_bank
//   Directed bench for led_blinker_bank with CLK_HZ=100 and TICK_HZ=10, so
//   one tick occurs every 10 clocks. NCH=4, HW=8, BW=4. A local copy of the
//   prescaler gives the tick phase, so writes can be aligned with a tick.
// ----------------------------------------------------------------------------
module tb_led_blinker_bank;
    localparam int CLK_HZ   = 100;
    localparam int TICK_HZ  = 10;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int NCH      = 4;
    localparam int HW       = 8;
    localparam int BW       = 4;
    localparam int CHW      = $clog2(NCH + 1);

    localparam int M_OFF   = 0;
    localparam int M_ON    = 1;
    localparam int M_BLINK = 2;
    localparam int M_BURST = 3;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] led;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;

    led_blinker_bank_if #(.NCH(NCH), .HW(HW), .BW(BW)) cfg_bus ();

    led_blinker_bank #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .NCH     (NCH),
        .HW      (HW),
        .BW      (BW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cfg  (cfg_bus),
        .led  (led),
        .busy (busy),
        .done (done)
    );

    int vectors     = 0;
    int miscompares = 0;
    int tb_pre;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference prescaler phase. When tb_pre == TICK_DIV-1 after an edge,
    // the next edge samples tick=1.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_pre <= 0;
        else     tb_pre <= (tb_pre == TICK_DIV - 1) ? 0 : tb_pre + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input int ch, input int mode, input int half, input int burst);
        cfg_bus.cfg_we    = 1'b1;
        cfg_bus.cfg_ch    = CHW'(ch);
        cfg_bus.cfg_mode  = 2'(mode);
        cfg_bus.cfg_half  = HW'(half);
        cfg_bus.cfg_burst = BW'(burst);
        step();
        cfg_bus.cfg_we    = 1'b0;
    endtask

    // Moves to the point where the next edge carries a tick.
    task automatic align_tick();
        while (tb_pre != TICK_DIV - 1) step();
    endtask

    // Counts the cycles for which led[ch] stays at level. The count is
    // bounded, so a stuck LED shows up as a wrong count.
    task automatic measure(input int ch, input logic level, output int n);
        n = 0;
        while (led[ch] == level && n < 200) begin
            n++;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int bad;

        rst               = 1'b1;
        cfg_bus.cfg_we    = 1'b0;
        cfg_bus.cfg_ch    = '0;
        cfg_bus.cfg_mode  = '0;
        cfg_bus.cfg_half  = '0;
        cfg_bus.cfg_burst = '0;

        // Reset state
        step();
        check("reset_led",  32'(led),  32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b0;
        step();

        // Out-of-range channel: nothing changes anywhere
        write_cfg(4, M_ON, 1, 3);
        check("oor_led",  32'(led),  32'h0);
        check("oor_busy", 32'(busy), 32'h0);
        repeat (30) step();
        check("oor_led_later",  32'(led),  32'h0);
        check("oor_busy_later", 32'(busy), 32'h0);
        check("oor_done_later", 32'(done), 32'h0);

        // BLINK ch1 half=3: high immediately, then 30/30 clk
        write_cfg(1, M_BLINK, 3, 0);
        check("ch1_led_start",  32'(led[1]),  32'h1);
        check("ch1_busy_start", 32'(busy[1]), 32'h1);
        measure(1, 1'b1, n);
        measure(1, 1'b0, n);
        check("ch1_low_clks", 32'(n), 32'd30);
        measure(1, 1'b1, n);
        check("ch1_high_clks", 32'(n), 32'd30);

        // Write ch3 in the same cycle as a tick: the tick is lost,
        // so the first toggle comes exactly 2 ticks after the write edge.
        align_tick();
        write_cfg(3, M_BLINK, 2, 0);
        check("ch3_led_start", 32'(led[3]), 32'h1);
        measure(3, 1'b1, n);
        check("ch3_first_high", 32'(n), 32'd20);
        measure(3, 1'b0, n);
        check("ch3_first_low", 32'(n), 32'd20);

        // BURST ch2 half=1 burst=2, written on a tick
        align_tick();
        write_cfg(2, M_BURST, 1, 2);
        check("ch2_busy_start", 32'(busy[2]), 32'h1);
        measure(2, 1'b1, n);
        check("ch2_pulse1_high", 32'(n), 32'd10);
        measure(2, 1'b0, n);
        check("ch2_gap_low", 32'(n), 32'd10);
        measure(2, 1'b1, n);
        check("ch2_pulse2_high", 32'(n), 32'd10);
        check("ch2_done_pulse", 32'(done[2]), 32'h1);
        check("ch2_busy_end",   32'(busy[2]), 32'h0);
        step();
        check("ch2_done_clear", 32'(done[2]), 32'h0);
        bad = 0;
        repeat (50) begin
            step();
            if (led[2] !== 1'b0 || done[2] !== 1'b0) bad++;
        end
        check("ch2_stays_off", 32'(bad), 32'd0);

        // half=0 acts as half=1: toggles every tick
        write_cfg(0, M_BLINK, 0, 0);
        measure(0, 1'b1, n);
        measure(0, 1'b0, n);
        check("ch0_half0_low", 32'(n), 32'd10);
        measure(0, 1'b1, n);
        check("ch0_half0_high", 32'(n), 32'd10);

        // ON then OFF on ch1: steady over 100 ticks each
        write_cfg(1, M_ON, 5, 0);
        check("ch1_on_busy", 32'(busy[1]), 32'h0);
        bad = 0;
        repeat (1000) begin
            if (led[1] !== 1'b1) bad++;
            step();
        end
        check("ch1_on_steady", 32'(bad), 32'd0);
        write_cfg(1, M_OFF, 5, 0);
        bad = 0;
        repeat (1000) begin
            if (led[1] !== 1'b0 || busy[1] !== 1'b0) bad++;
            step();
        end
        check("ch1_off_steady", 32'(bad), 32'd0);

        // Reset mid-blink, asserted between edges
        write_cfg(0, M_BLINK, 2, 0);
        check("ch0_pre_reset_led", 32'(led[0]), 32'h1);
        repeat (3) step();
        #3;
        rst = 1'b1;
        #1;
        check("midrst_led",  32'(led),  32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        #2;
        rst = 1'b0;
        repeat (15) step();
        check("post_rst_led",  32'(led),  32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
